// File: rtl/iq_frame_scheduler_pkg.sv
// Shared constants for the I/Q frame scheduler: sample widths, frame phases,
// arbitration modes and sequencer state encodings.
package iq_frame_scheduler_pkg;

    localparam int ILength      = 14;
    localparam int QLength      = 14;
    localparam int IQ_FRAME_LEN = 16;

    localparam logic [3:0] IQ_SLOT_PHASE  = 4'd8;
    localparam logic [3:0] IQ_QLOAD_PHASE = 4'd0;
    localparam logic [3:0] IQ_LAST_PHASE  = 4'(IQ_FRAME_LEN - 1);

    localparam logic [1:0] MODE_DATA     = 2'd0;
    localparam logic [1:0] MODE_CAL      = 2'd1;
    localparam logic [1:0] MODE_CAL_PRIO = 2'd2;
    localparam logic [1:0] MODE_RR       = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/iq_source_arbiter.sv
// Grant logic choosing the datapath or cal source for one serializer slot.
// Latency: combinational grant; round-robin pointer updates on the transfer edge.
// Backpressure: ready is raised to at most one source, only while slot_active.
module iq_source_arbiter
    import iq_frame_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       data_valid,
    input  logic       cal_valid,
    input  logic       slot_active,
    output logic       data_ready,
    output logic       cal_ready,
    output logic       sel_cal
);

    logic rr_cal;
    logic grant_cal;
    logic xfer;

    always_comb begin
        grant_cal = 1'b0;
        case (mode)
            MODE_DATA:     grant_cal = 1'b0;
            MODE_CAL:      grant_cal = 1'b1;
            MODE_CAL_PRIO: grant_cal = cal_valid;
            // round-robin: take the source whose turn it is, else the other if it has a sample
            default:       grant_cal = rr_cal ? (cal_valid || !data_valid)
                                              : (cal_valid && !data_valid);
        endcase
    end

    assign data_ready = slot_active && !grant_cal;
    assign cal_ready  = slot_active &&  grant_cal;
    assign sel_cal    = grant_cal;
    assign xfer       = (data_valid && data_ready) || (cal_valid && cal_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_cal <= 1'b0;
        end else if (xfer) begin
            rr_cal <= !grant_cal;
        end
    end

endmodule

// File: rtl/iq_frame_scheduler.sv
// Picks one I/Q sample per 16-clock serializer frame and sequences ser_start.
// Latency: sample taken at the frame_cnt=8 slot is sent as I and Q in the next frame.
// Backpressure: sources hold valid until their single-cycle ready; a missed slot sends zeros.
module iq_frame_scheduler
    import iq_frame_scheduler_pkg::*;
#(
    parameter int ILEN   = ILength,
    parameter int QLEN   = QLength,
    parameter int UCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [ILEN-1:0]   data_i,
    input  logic [QLEN-1:0]   data_q,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [ILEN-1:0]   cal_i,
    input  logic [QLEN-1:0]   cal_q,
    input  logic              cal_valid,
    output logic              cal_ready,
    output logic              ser_start,
    output logic [ILEN-1:0]   ser_i,
    output logic [QLEN-1:0]   ser_q,
    output logic [3:0]        frame_cnt,
    output logic              busy,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);

    logic [1:0]      state;
    logic [QLEN-1:0] q_pend;
    logic            stop_wrap;
    logic            in_frame;
    logic            slot_active;
    logic            sel_cal;
    logic            xfer;
    logic [ILEN-1:0] samp_i;
    logic [QLEN-1:0] samp_q;

    assign in_frame    = (state == ST_RUN) || (state == ST_STOP);
    assign slot_active = ((state == ST_PRIME) && enable) ||
                         (in_frame && (frame_cnt == IQ_SLOT_PHASE));
    assign xfer        = (data_valid && data_ready) || (cal_valid && cal_ready);
    assign samp_i      = sel_cal ? cal_i : data_i;
    assign samp_q      = sel_cal ? cal_q : data_q;
    assign busy        = (state != ST_IDLE);

    iq_source_arbiter u_arb (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .data_valid  (data_valid),
        .cal_valid   (cal_valid),
        .slot_active (slot_active),
        .data_ready  (data_ready),
        .cal_ready   (cal_ready),
        .sel_cal     (sel_cal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ser_start    <= 1'b0;
            ser_i        <= '0;
            ser_q        <= '0;
            q_pend       <= '0;
            frame_cnt    <= '0;
            stop_wrap    <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ser_start <= 1'b0;
                    frame_cnt <= '0;
                    stop_wrap <= 1'b0;
                    if (enable) begin
                        state <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (xfer) begin
                        ser_i     <= samp_i;
                        q_pend    <= samp_q;
                        ser_start <= 1'b1;
                        frame_cnt <= '0;
                        state     <= ST_RUN;
                    end
                end
                default: begin
                    frame_cnt <= frame_cnt + 4'd1;
                    if (slot_active) begin
                        if (xfer) begin
                            ser_i  <= samp_i;
                            q_pend <= samp_q;
                        end else begin
                            ser_i    <= '0;
                            q_pend   <= '0;
                            underrun <= 1'b1;
                            if (underrun_cnt != {UCNT_W{1'b1}}) begin
                                underrun_cnt <= underrun_cnt + UCNT_W'(1);
                            end
                        end
                    end
                    if (frame_cnt == IQ_QLOAD_PHASE) begin
                        ser_q <= q_pend;
                    end
                    if (state == ST_RUN) begin
                        if (!enable) begin
                            state     <= ST_STOP;
                            stop_wrap <= (frame_cnt == IQ_LAST_PHASE);
                        end
                    end else begin
                        if (frame_cnt == IQ_LAST_PHASE) begin
                            stop_wrap <= 1'b1;
                        end
                        // drop start one edge after the wrap so QDATA of the last frame completes
                        if ((frame_cnt == IQ_QLOAD_PHASE) && stop_wrap) begin
                            ser_start <= 1'b0;
                            frame_cnt <= '0;
                            state     <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
